ahb2gpio: RTL and testbench

Parametrised AHB-Lite slave providing a general-purpose I/O port of GPIO_W pins. It sits on the same system bus as the existing single-register LED peripheral and is its next generation. It adds per-pin direction control, synchronised input sampling, and atomic set/clear/toggle of output bits. It also adds rising-edge interrupt capture with per-pin enable. All transfers are zero-wait-state and the block drives a single interrupt line to the processor.

---
 rtl/ahb2gpio_pkg.sv | 44 ++++
 rtl/gpio_sync.sv | 41 ++++
 rtl/ahb2gpio.sv | 144 ++++++++++++++
 tb/tb_ahb2gpio.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2gpio_pkg.sv
// -----------------------------------------------------------------------------
// ahb2gpio_pkg : register offsets, HSIZE encodings and byte-lane helpers
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package ahb2gpio_pkg;

  localparam logic [4:0] OFS_DOUT  = 5'h00;
  localparam logic [4:0] OFS_DIR   = 5'h04;
  localparam logic [4:0] OFS_DIN   = 5'h08;
  localparam logic [4:0] OFS_SET   = 5'h0C;
  localparam logic [4:0] OFS_CLR   = 5'h10;
  localparam logic [4:0] OFS_TGL   = 5'h14;
  localparam logic [4:0] OFS_IEN   = 5'h18;
  localparam logic [4:0] OFS_ISTAT = 5'h1C;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Little-endian lane selection; unsupported sizes fall back to a full word.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      b[8*i +: 8] = {8{lanes[i]}};
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync : multi-stage input synchroniser with rising-edge detect
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module gpio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic [WIDTH-1:0] din_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stage[s] <= '0;
      end
      din_d <= '0;
    end else begin
      stage[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        stage[s] <= stage[s-1];
      end
      din_d <= stage[SYNC_STAGES-1];
    end
  end

  assign din  = stage[SYNC_STAGES-1];
  assign rise = din & ~din_d;

endmodule

`default_nettype wire

// File: rtl/ahb2gpio.sv
// -----------------------------------------------------------------------------
// ahb2gpio : zero-wait AHB-Lite GPIO slave with atomics and edge interrupts
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module ahb2gpio
  import ahb2gpio_pkg::*;
#(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  output logic              HREADYOUT,
  output logic [31:0]       HRDATA,
  input  logic [GPIO_W-1:0] GPIO_IN,
  output logic [GPIO_W-1:0] GPIO_OUT,
  output logic [GPIO_W-1:0] GPIO_OE,
  output logic              GPIO_IRQ
);

  logic              sel_q;
  logic              write_q;
  logic [4:0]        addr_q;
  logic [1:0]        trans_q;
  logic [2:0]        size_q;

  logic [GPIO_W-1:0] dout, dir, ien, istat;
  logic [GPIO_W-1:0] dout_nx, dir_nx, ien_nx, istat_clr, istat_nx;
  logic [GPIO_W-1:0] din, rise;
  logic              irq;

  logic              wr_en;
  logic [2:0]        reg_idx;
  logic [31:0]       wr_mask32, wr_bits32;
  logic [GPIO_W-1:0] wr_mask, wr_bits;
  logic [31:0]       rdata;
  logic              unused_ok;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      trans_q <= '0;
      size_q  <= '0;
    end else if (HREADY) begin
      sel_q   <= HSEL;
      write_q <= HWRITE;
      addr_q  <= HADDR[4:0];
      trans_q <= HTRANS;
      size_q  <= HSIZE;
    end
  end

  gpio_sync #(
    .WIDTH       (GPIO_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .pin_in (GPIO_IN),
    .din    (din),
    .rise   (rise)
  );

  assign wr_en     = sel_q & write_q & trans_q[1];
  assign reg_idx   = addr_q[4:2];
  assign wr_mask32 = lane_bits(lane_mask(size_q, addr_q[1:0]));
  assign wr_bits32 = HWDATA & wr_mask32;
  assign wr_mask   = wr_mask32[GPIO_W-1:0];
  assign wr_bits   = wr_bits32[GPIO_W-1:0];

  // Unwritten lanes are zero in wr_bits, so SET/CLR/TGL/ISTAT use it directly.
  always_comb begin
    dout_nx   = dout;
    dir_nx    = dir;
    ien_nx    = ien;
    istat_clr = '0;
    if (wr_en) begin
      case (reg_idx)
        OFS_DOUT[4:2]:  dout_nx   = (dout & ~wr_mask) | wr_bits;
        OFS_DIR[4:2]:   dir_nx    = (dir & ~wr_mask) | wr_bits;
        OFS_SET[4:2]:   dout_nx   = dout | wr_bits;
        OFS_CLR[4:2]:   dout_nx   = dout & ~wr_bits;
        OFS_TGL[4:2]:   dout_nx   = dout ^ wr_bits;
        OFS_IEN[4:2]:   ien_nx    = (ien & ~wr_mask) | wr_bits;
        OFS_ISTAT[4:2]: istat_clr = wr_bits;
        default:        ;
      endcase
    end
  end

  // A fresh edge overrides a simultaneous write-1-to-clear.
  assign istat_nx = (istat & ~istat_clr) | rise;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dout  <= '0;
      dir   <= '0;
      ien   <= '0;
      istat <= '0;
      irq   <= 1'b0;
    end else begin
      dout  <= dout_nx;
      dir   <= dir_nx;
      ien   <= ien_nx;
      istat <= istat_nx;
      irq   <= |(istat & ien);
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      OFS_DOUT[4:2], OFS_SET[4:2],
      OFS_CLR[4:2], OFS_TGL[4:2]: rdata[GPIO_W-1:0] = dout;
      OFS_DIR[4:2]:               rdata[GPIO_W-1:0] = dir;
      OFS_DIN[4:2]:               rdata[GPIO_W-1:0] = din;
      OFS_IEN[4:2]:               rdata[GPIO_W-1:0] = ien;
      OFS_ISTAT[4:2]:             rdata[GPIO_W-1:0] = istat;
      default:                    rdata = '0;
    endcase
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign GPIO_OUT  = dout;
  assign GPIO_OE   = dir;
  assign GPIO_IRQ  = irq;

  assign unused_ok = &{1'b0, HADDR[31:5], wr_mask32, wr_bits32};

endmodule

`default_nettype wire

// File: tb/tb_ahb2gpio.sv
// -----------------------------------------------------------------------------
// tb_ahb2gpio : directed, table-driven self-checking bench for ahb2gpio
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ahb2gpio;
  import ahb2gpio_pkg::*;

  localparam int GPIO_W      = 16;
  localparam int SYNC_STAGES = 2;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic              HSEL = 1'b0;
  logic              HREADY = 1'b1;
  logic [31:0]       HADDR = '0;
  logic [1:0]        HTRANS = '0;
  logic              HWRITE = 1'b0;
  logic [2:0]        HSIZE = '0;
  logic [31:0]       HWDATA = '0;
  logic              HREADYOUT;
  logic [31:0]       HRDATA;
  logic [GPIO_W-1:0] GPIO_IN = '0;
  logic [GPIO_W-1:0] GPIO_OUT;
  logic [GPIO_W-1:0] GPIO_OE;
  logic              GPIO_IRQ;

  int total = 0;
  int bad   = 0;

  ahb2gpio #(.GPIO_W(GPIO_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .GPIO_IRQ(GPIO_IRQ)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addr_phase(input logic sel, input logic [1:0] trans, input logic wr,
                            input logic [31:0] addr, input logic [2:0] size);
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0;
  endtask

  task automatic xfer_write(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] data);
    addr_phase(sel, trans, 1'b1, addr, size);
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    addr_phase(1'b1, T_NONSEQ, 1'b0, addr, HSIZE_WORD);
    @(posedge HCLK); #1;
    data = HRDATA;
    bus_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gpio_out"}, 32'(GPIO_OUT), 32'h0);
    check({tag, "_gpio_oe"},  32'(GPIO_OE),  32'h0);
    check({tag, "_irq"},      32'(GPIO_IRQ), 32'h0);
    check({tag, "_hrdata"},   HRDATA,        32'h0);
    check({tag, "_hreadyout"}, 32'(HREADYOUT), 32'h1);
  endtask

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{1'b1, 32'h00, HSIZE_WORD, 32'h000000F0, 32'h00, 32'h000000F0};
    vecs[1]  = '{1'b1, 32'h0C, HSIZE_WORD, 32'h0000000F, 32'h00, 32'h000000FF};
    vecs[2]  = '{1'b1, 32'h10, HSIZE_WORD, 32'h00000030, 32'h00, 32'h000000CF};
    vecs[3]  = '{1'b1, 32'h14, HSIZE_WORD, 32'h00000101, 32'h00, 32'h000001CE};
    vecs[4]  = '{1'b0, 32'h00, HSIZE_WORD, 32'h00000000, 32'h0C, 32'h000001CE};
    vecs[5]  = '{1'b0, 32'h00, HSIZE_WORD, 32'h00000000, 32'h10, 32'h000001CE};
    vecs[6]  = '{1'b0, 32'h00, HSIZE_WORD, 32'h00000000, 32'h14, 32'h000001CE};
    vecs[7]  = '{1'b1, 32'h00, HSIZE_WORD, 32'h0000FFFF, 32'h00, 32'h0000FFFF};
    vecs[8]  = '{1'b1, 32'h01, HSIZE_BYTE, 32'hABCD12EF, 32'h00, 32'h000012FF};
    vecs[9]  = '{1'b1, 32'h1A, HSIZE_HALF, 32'hFFFF0000, 32'h18, 32'h00000000};
    vecs[10] = '{1'b1, 32'h18, HSIZE_HALF, 32'hFFFF1234, 32'h18, 32'h00001234};
    vecs[11] = '{1'b1, 32'h15, HSIZE_BYTE, 32'h0000F0FF, 32'h00, 32'h0000E2FF};
    vecs[12] = '{1'b1, 32'h08, HSIZE_WORD, 32'h0000FFFF, 32'h08, 32'h00000000};
    vecs[13] = '{1'b1, 32'h04, HSIZE_WORD, 32'hFFFFFFFF, 32'h04, 32'h0000FFFF};
    vecs[14] = '{1'b0, 32'h00, HSIZE_WORD, 32'h00000000, 32'h20, 32'h0000E2FF};
    vecs[15] = '{1'b1, 32'h12, HSIZE_HALF, 32'h0000FFFF, 32'h00, 32'h0000E2FF};
    vecs[16] = '{1'b1, 32'h10, HSIZE_BYTE, 32'h0000FF0F, 32'h00, 32'h0000E2F0};
    vecs[17] = '{1'b1, 32'h18, HSIZE_WORD, 32'h00000000, 32'h18, 32'h00000000};
    vecs[18] = '{1'b1, 32'h04, HSIZE_WORD, 32'h00000F0F, 32'h04, 32'h00000F0F};

    // Power-on reset
    repeat (3) @(posedge HCLK);
    #1;
    check_reset_outputs("por");
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Back-to-back write then read of DOUT
    addr_phase(1'b1, T_NONSEQ, 1'b1, 32'h00, HSIZE_WORD);
    @(posedge HCLK); #1;
    HWDATA = 32'h0000A5A5;
    addr_phase(1'b1, T_NONSEQ, 1'b0, 32'h00, HSIZE_WORD);
    @(posedge HCLK); #1;
    check("b2b_read_dout", HRDATA, 32'h0000A5A5);
    check("b2b_gpio_out", 32'(GPIO_OUT), 32'h0000A5A5);
    bus_idle();
    xfer_write(1'b1, T_NONSEQ, 32'h04, HSIZE_WORD, 32'h0000FFFF);
    check("dir_gpio_oe", 32'(GPIO_OE), 32'h0000FFFF);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr) xfer_write(1'b1, T_NONSEQ, vecs[i].addr, vecs[i].size, vecs[i].wdata);
      ahb_read(vecs[i].chk, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    check("pins_out", 32'(GPIO_OUT), 32'h0000E2F0);
    check("pins_oe",  32'(GPIO_OE),  32'h00000F0F);

    // Non-transfers must not write
    xfer_write(1'b1, T_IDLE, 32'h00, HSIZE_WORD, 32'h00000000);
    ahb_read(32'h00, rd); check("idle_nowrite", rd, 32'h0000E2F0);
    xfer_write(1'b1, T_BUSY, 32'h00, HSIZE_WORD, 32'h00000000);
    ahb_read(32'h00, rd); check("busy_nowrite", rd, 32'h0000E2F0);
    xfer_write(1'b0, T_NONSEQ, 32'h00, HSIZE_WORD, 32'h00000000);
    ahb_read(32'h00, rd); check("nosel_nowrite", rd, 32'h0000E2F0);

    // HREADY low: sampled read of DIR is held, stalled write never lands
    addr_phase(1'b1, T_NONSEQ, 1'b0, 32'h04, HSIZE_WORD);
    @(posedge HCLK); #1;
    HREADY = 1'b0;
    addr_phase(1'b1, T_NONSEQ, 1'b1, 32'h00, HSIZE_WORD);
    HWDATA = 32'h00000000;
    for (int k = 0; k < 2; k++) begin
      @(posedge HCLK); #1;
      check($sformatf("stall_hold%0d", k), HRDATA, 32'h00000F0F);
    end
    HREADY = 1'b1;
    bus_idle();
    repeat (2) @(posedge HCLK);
    #1;
    ahb_read(32'h00, rd); check("stall_nowrite", rd, 32'h0000E2F0);

    // DIN latency via continuous reads
    addr_phase(1'b1, T_NONSEQ, 1'b0, 32'h08, HSIZE_WORD);
    @(posedge HCLK); #1;
    GPIO_IN = 16'h5A3C;
    for (int k = 1; k <= SYNC_STAGES; k++) begin
      @(posedge HCLK); #1;
      check($sformatf("din_edge%0d", k), HRDATA, (k >= SYNC_STAGES) ? 32'h00005A3C : 32'h0);
    end
    bus_idle();
    GPIO_IN = '0;
    repeat (4) @(posedge HCLK);
    #1;
    xfer_write(1'b1, T_NONSEQ, 32'h1C, HSIZE_WORD, 32'h0000FFFF);
    ahb_read(32'h1C, rd); check("istat_cleared", rd, 32'h0);

    // Interrupt capture timing
    xfer_write(1'b1, T_NONSEQ, 32'h18, HSIZE_WORD, 32'h00000004);
    addr_phase(1'b1, T_NONSEQ, 1'b0, 32'h1C, HSIZE_WORD);
    @(posedge HCLK); #1;
    GPIO_IN[2] = 1'b1;
    for (int k = 1; k <= SYNC_STAGES + 2; k++) begin
      @(posedge HCLK); #1;
      check($sformatf("istat_edge%0d", k), HRDATA, (k >= SYNC_STAGES + 1) ? 32'h4 : 32'h0);
      check($sformatf("irq_edge%0d", k), 32'(GPIO_IRQ), (k >= SYNC_STAGES + 2) ? 32'h1 : 32'h0);
    end
    bus_idle();
    xfer_write(1'b1, T_NONSEQ, 32'h1C, HSIZE_WORD, 32'h00000004);
    check("irq_after_w1c", 32'(GPIO_IRQ), 32'h1);
    @(posedge HCLK); #1;
    check("irq_drop", 32'(GPIO_IRQ), 32'h0);
    ahb_read(32'h1C, rd); check("istat_w1c", rd, 32'h0);

    // New edge landing on the same cycle as a W1C
    GPIO_IN[2] = 1'b0;
    repeat (4) @(posedge HCLK);
    #1;
    GPIO_IN[2] = 1'b1;
    repeat (SYNC_STAGES - 1) @(posedge HCLK);
    #1;
    xfer_write(1'b1, T_NONSEQ, 32'h1C, HSIZE_WORD, 32'h00000004);
    ahb_read(32'h1C, rd); check("set_beats_w1c", rd, 32'h4);
    @(posedge HCLK); #1;
    check("irq_reasserted", 32'(GPIO_IRQ), 32'h1);

    // Reset in the data phase of a DOUT write
    GPIO_IN = '0;
    repeat (4) @(posedge HCLK);
    #1;
    addr_phase(1'b1, T_NONSEQ, 1'b1, 32'h00, HSIZE_WORD);
    @(posedge HCLK); #1;
    HWDATA = 32'h00001111;
    bus_idle();
    HRESETn = 1'b0;
    #2;
    check_reset_outputs("midrst");
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    ahb_read(32'h00, rd); check("rst_dout",  rd, 32'h0);
    ahb_read(32'h04, rd); check("rst_dir",   rd, 32'h0);
    ahb_read(32'h18, rd); check("rst_ien",   rd, 32'h0);
    ahb_read(32'h1C, rd); check("rst_istat", rd, 32'h0);
    check("rst_irq", 32'(GPIO_IRQ), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
